// File: rtl/umi_pkg.sv
// UMI packet layout, command codes, AXI response codes and the read-bridge
// FSM state type shared by the AXI-lite to UMI read path.
package umi_pkg;

  localparam int UMI_W    = 256;
  localparam int CMD_LSB  = 0;
  localparam int CMD_MSB  = 7;
  localparam int DST_LSB  = 8;
  localparam int DST_MSB  = 71;
  localparam int SRC_LSB  = 72;
  localparam int SRC_MSB  = 135;
  localparam int DATA_LSB = 136;
  localparam int DATA_MSB = 255;

  localparam logic [7:0] CMD_READ_REQ  = 8'h01;
  localparam logic [7:0] CMD_READ_RESP = 8'h02;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Read requests carry no payload, so the data field stays zero.
  function automatic logic [UMI_W-1:0] umi_pack_read_req(input logic [63:0] dst,
                                                         input logic [63:0] src);
    logic [UMI_W-1:0] pkt;
    pkt                   = '0;
    pkt[CMD_MSB:CMD_LSB]  = CMD_READ_REQ;
    pkt[DST_MSB:DST_LSB]  = dst;
    pkt[SRC_MSB:SRC_LSB]  = src;
    return pkt;
  endfunction

endpackage

// File: rtl/axil_umi_read_bridge.sv
// AXI-lite read-only slave: each AR becomes a UMI read request; the matching
// UMI response (or a timeout SLVERR) is returned on R. One read in flight.
module axil_umi_read_bridge
  import umi_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [63:0] SRC_ADDR   = 64'h0,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [UMI_W-1:0]      umi_packet_tx,
  output logic                  umi_valid_tx,
  input  logic                  umi_ready_tx,
  input  logic [UMI_W-1:0]      umi_packet_rx,
  input  logic                  umi_valid_rx,
  output logic                  umi_ready_rx,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t                  state_q;
  logic                    arready_q;
  logic                    rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;
  logic [UMI_W-1:0]        packet_tx_q;
  logic                    valid_tx_q;
  logic [15:0]             drop_count_q, drop_count_d;
  logic [31:0]             tmo_cnt_q, tmo_cnt_d;

  logic                    ready_rx;
  logic                    rx_accept;
  logic                    rx_match;
  logic                    tmo_hit;

  // Protection bits and the unused upper payload are intentionally ignored.
  logic unused_ok;
  assign unused_ok = &{1'b0, s_axil_arprot, umi_packet_rx};

  always_comb begin
    ready_rx  = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    rx_accept = ready_rx && umi_valid_rx;
    rx_match  = rx_accept && (state_q == ST_WAIT)
                && (umi_packet_rx[CMD_MSB:CMD_LSB] == CMD_READ_RESP)
                && (umi_packet_rx[DST_MSB:DST_LSB] == SRC_ADDR);
    tmo_hit   = (TIMEOUT != 0) && (state_q == ST_WAIT) && (tmo_cnt_q == TMO_LAST);
  end

  // Every accepted packet that is not the awaited response is discarded.
  always_comb begin
    drop_count_d = drop_count_q;
    if (rx_accept && !rx_match && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_q == ST_SEND) && umi_ready_tx) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ST_WAIT) && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_count_q <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      packet_tx_q <= '0;
      valid_tx_q  <= 1'b0;
    end else begin
      arready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s_axil_arvalid) begin
            arready_q   <= 1'b1;
            packet_tx_q <= umi_pack_read_req(64'(s_axil_araddr), SRC_ADDR);
            valid_tx_q  <= 1'b1;
            state_q     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (umi_ready_tx) begin
            valid_tx_q <= 1'b0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response arriving on the timeout cycle still wins.
          if (rx_match) begin
            rdata_q  <= umi_packet_rx[DATA_LSB +: DATA_WIDTH];
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b1;
            state_q  <= ST_RESP;
          end else if (tmo_hit) begin
            rdata_q  <= '0;
            rresp_q  <= RESP_SLVERR;
            rvalid_q <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (s_axil_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_axil_arready = arready_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign umi_packet_tx  = packet_tx_q;
  assign umi_valid_tx   = valid_tx_q;
  assign umi_ready_rx   = ready_rx;
  assign drop_count     = drop_count_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axil_umi_read_bridge.sv
// Scoreboard bench for axil_umi_read_bridge: expected TX packets and R beats
// are queued by the stimulus and checked by an independent monitor.
module tb_axil_umi_read_bridge;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          TMO = 16;
  localparam logic [63:0] SRC = 64'h0;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [AW-1:0]  s_axil_araddr = '0;
  logic [2:0]     s_axil_arprot = 3'b0;
  logic           s_axil_arvalid = 1'b0;
  logic           s_axil_arready;
  logic [DW-1:0]  s_axil_rdata;
  logic [1:0]     s_axil_rresp;
  logic           s_axil_rvalid;
  logic           s_axil_rready = 1'b1;
  logic [255:0]   umi_packet_tx;
  logic           umi_valid_tx;
  logic           umi_ready_tx = 1'b1;
  logic [255:0]   umi_packet_rx = '0;
  logic           umi_valid_rx = 1'b0;
  logic           umi_ready_rx;
  logic [15:0]    drop_count;
  logic           busy;

  axil_umi_read_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_ADDR(SRC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .umi_packet_tx(umi_packet_tx), .umi_valid_tx(umi_valid_tx),
    .umi_ready_tx(umi_ready_tx), .umi_packet_rx(umi_packet_rx),
    .umi_valid_rx(umi_valid_rx), .umi_ready_rx(umi_ready_rx),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int tx_hs = 0;
  int tx_hs_cyc = 0;
  int r_hs = 0;
  int exp_drop = 0;
  logic [31:0] exp_tx[$];
  logic [33:0] exp_r[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [255:0] mk_pkt(input logic [7:0] cmd, input logic [63:0] dst,
                                          input logic [63:0] src, input logic [119:0] data);
    return {data, src, dst, cmd};
  endfunction

  function automatic logic [255:0] resp_pkt(input logic [31:0] d);
    return mk_pkt(8'h02, SRC, 64'h1234, 120'(d));
  endfunction

  // Monitor: compares every TX and R handshake against the queued expectations.
  initial begin : monitor
    logic [31:0] a;
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (umi_valid_tx && umi_ready_tx) begin
          tx_hs++;
          tx_hs_cyc = cyc;
          if (exp_tx.size() == 0) fail_now("tx_unexpected_request");
          else begin
            a = exp_tx.pop_front();
            chk("tx_packet", umi_packet_tx, mk_pkt(8'h01, {32'h0, a}, SRC, 120'h0));
          end
        end
        if (s_axil_rvalid && s_axil_rready) begin
          r_hs++;
          if (exp_r.size() == 0) fail_now("r_unexpected_beat");
          else begin
            e = exp_r.pop_front();
            chk("r_data", 256'(s_axil_rdata), 256'(e[33:2]));
            chk("r_resp", 256'(s_axil_rresp), 256'(e[1:0]));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ar_read(input logic [31:0] addr);
    int n;
    exp_tx.push_back(addr);
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axil_arready && n < 50);
    if (!s_axil_arready) fail_now("ar_timeout");
    tick();
    s_axil_arvalid = 1'b0;
  endtask

  task automatic wait_tx(input int prev);
    int n;
    n = 0;
    while (tx_hs <= prev && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (tx_hs <= prev) fail_now("tx_handshake_timeout");
    tick();
  endtask

  task automatic rx_send(input logic [255:0] pkt);
    int n;
    umi_packet_rx = pkt;
    umi_valid_rx  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!umi_ready_rx && n < 50);
    if (!umi_ready_rx) fail_now("rx_ready_timeout");
    tick();
    umi_valid_rx = 1'b0;
  endtask

  task automatic wait_r();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_axil_rvalid && s_axil_rready) && n < 100);
    if (!(s_axil_rvalid && s_axil_rready)) fail_now("r_handshake_timeout");
    tick();
  endtask

  task automatic chk_reset_state();
    @(negedge clk);
    chk("rst_arready", 256'(s_axil_arready), 256'(0));
    chk("rst_rvalid", 256'(s_axil_rvalid), 256'(0));
    chk("rst_valid_tx", 256'(umi_valid_tx), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_rdata", 256'(s_axil_rdata), 256'(0));
    chk("rst_rresp", 256'(s_axil_rresp), 256'(0));
    chk("rst_packet_tx", umi_packet_tx, 256'(0));
    chk("rst_drop_count", 256'(drop_count), 256'(0));
    chk("rst_ready_rx", 256'(umi_ready_rx), 256'(1));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog_expired");
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    int prev, t0, r0, n, k;
    logic [31:0] a, d, d2, cap_a;
    logic [255:0] cap;
    logic [7:0] jc;

    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    chk_reset_state();
    tick();

    // Basic read with a 5-cycle responder delay.
    prev = tx_hs;
    exp_r.push_back({32'hCAFEF00D, 2'b00});
    ar_read(32'h10000004);
    wait_tx(prev);
    repeat (4) tick();
    chk("basic_rvalid_before_rx", 256'(s_axil_rvalid), 256'(0));
    rx_send(resp_pkt(32'hCAFEF00D));
    @(negedge clk);
    chk("basic_rvalid_latency", 256'(s_axil_rvalid), 256'(1));
    tick();
    tick();

    // TX backpressure: request must hold stable.
    umi_ready_tx = 1'b0;
    prev = tx_hs;
    a = $urandom;
    d = $urandom;
    exp_r.push_back({d, 2'b00});
    ar_read(a);
    @(negedge clk);
    cap = umi_packet_tx;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("txbp_valid_held", 256'(umi_valid_tx), 256'(1));
      chk("txbp_packet_stable", umi_packet_tx, cap);
    end
    chk("txbp_no_handshake", 256'(tx_hs), 256'(prev));
    tick();
    umi_ready_tx = 1'b1;
    wait_tx(prev);
    rx_send(resp_pkt(d));
    wait_r();

    // Timeout then a late response that must be dropped.
    prev = tx_hs;
    exp_r.push_back({32'h0, 2'b10});
    ar_read($urandom);
    wait_tx(prev);
    t0 = tx_hs_cyc;
    n = 0;
    while (!s_axil_rvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", 256'(cyc - t0), 256'(17));
    tick();
    tick();
    r0 = r_hs;
    rx_send(resp_pkt(32'h0BADBEEF));
    exp_drop++;
    repeat (3) tick();
    chk("timeout_late_dropped", 256'(drop_count), 256'(exp_drop));
    chk("timeout_no_extra_r", 256'(r_hs), 256'(r0));

    // Wrong packets while waiting, then the real response.
    prev = tx_hs;
    d = $urandom;
    exp_r.push_back({d, 2'b00});
    ar_read($urandom);
    wait_tx(prev);
    rx_send(mk_pkt(8'h03, SRC, 64'h0, 120'(32'h11111111)));
    rx_send(mk_pkt(8'h02, 64'h5, 64'h0, 120'(32'h22222222)));
    exp_drop += 2;
    rx_send(resp_pkt(d));
    wait_r();
    chk("wrong_pkts_dropped", 256'(drop_count), 256'(exp_drop));

    // R backpressure with a second AR already pending.
    s_axil_rready = 1'b0;
    a = $urandom;
    d = $urandom;
    d2 = $urandom;
    exp_r.push_back({d, 2'b00});
    exp_r.push_back({d2, 2'b00});
    prev = tx_hs;
    ar_read(a);
    wait_tx(prev);
    rx_send(resp_pkt(d));
    prev = tx_hs;
    cap_a = $urandom;
    exp_tx.push_back(cap_a);
    s_axil_araddr = cap_a;
    s_axil_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rbp_rvalid_held", 256'(s_axil_rvalid), 256'(1));
      chk("rbp_rdata_stable", 256'(s_axil_rdata), 256'(d));
      chk("rbp_no_arready", 256'(s_axil_arready), 256'(0));
    end
    tick();
    s_axil_rready = 1'b1;
    @(negedge clk);
    chk("b2b_arready_at_rhs", 256'(s_axil_arready), 256'(0));
    @(negedge clk);
    chk("b2b_arready_idle_cycle", 256'(s_axil_arready), 256'(0));
    @(negedge clk);
    chk("b2b_arready_after", 256'(s_axil_arready), 256'(1));
    tick();
    s_axil_arvalid = 1'b0;
    wait_tx(prev);
    rx_send(resp_pkt(d2));
    wait_r();

    // Randomized reads with backpressure and junk traffic.
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      d = $urandom;
      exp_r.push_back({d, 2'b00});
      prev = tx_hs;
      umi_ready_tx = 1'b0;
      s_axil_rready = 1'b0;
      ar_read(a);
      k = $urandom_range(0, 3);
      repeat (k) tick();
      umi_ready_tx = 1'b1;
      wait_tx(prev);
      k = $urandom_range(0, 4);
      repeat (k) tick();
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          jc = 8'($urandom);
          if (jc == 8'h02) jc = 8'h7F;
          rx_send(mk_pkt(jc, SRC, 64'h0, 120'($urandom)));
        end else begin
          rx_send(mk_pkt(8'h02, 64'($urandom_range(1, 1000)), 64'h0, 120'($urandom)));
        end
        exp_drop++;
      end
      rx_send(resp_pkt(d));
      k = $urandom_range(0, 3);
      repeat (k) tick();
      s_axil_rready = 1'b1;
      wait_r();
    end
    chk("random_drop_count", 256'(drop_count), 256'(exp_drop));
    chk("random_all_r_seen", 256'(exp_r.size()), 256'(0));

    // Reset while waiting for a response.
    prev = tx_hs;
    ar_read($urandom);
    wait_tx(prev);
    tick();
    r0 = r_hs;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_drop = 0;
    chk_reset_state();
    tick();
    rx_send(resp_pkt(32'h5A5A5A5A));
    exp_drop++;
    repeat (4) tick();
    chk("reset_late_dropped", 256'(drop_count), 256'(exp_drop));
    chk("reset_no_r_beat", 256'(r_hs), 256'(r0));
    chk("reset_tx_queue_empty", 256'(exp_tx.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
